id_ex_pipe_reg: RTL
===================

Name: id_ex_pipe_reg

Overview:
- ID/EX pipeline register of the 5-stage RV32I core. Sits directly downstream of the decode-stage control unit and register file read.
- Captures the decoded control bundle, operands, immediate and register indices each cycle, and presents them to the EX stage.
- Inserts bubbles on load-use stalls.
- Owns the ecall-halt drain sequencer: freezes younger instructions and raises is_halted once the halting ecall has retired through WB.

Parameters:
- XLEN, 32, datapath width of pc/operand/immediate fields
- DRAIN_CYCLES, 3, edges from ecall capture in EX until is_halted asserts (EX->MEM->WB retire)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- id_valid  in  1  decode slot holds a real instruction
- id_bubble  in  1  hazard unit requests a bubble (load-use stall)
- id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_write_enable, id_is_ecall  in  1 each  control bundle from decode
- id_halt_req  in  1  forwarded x17 == 10 at decode
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN each  decode datapath values
- id_funct3  in  3, id_funct7  in  7  ALU-control inputs
- id_rs1, id_rs2, id_rd  in  5 each  register indices
- ex_valid  out  1  EX slot holds a real instruction
- ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_write_enable, ex_is_ecall  out  1 each  registered control bundle
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN each
- ex_funct3  out  3, ex_funct7  out  7, ex_rs1/ex_rs2/ex_rd  out  5 each
- halt_pending  out  1  halting ecall captured; drain in progress
- is_halted  out  1  sticky halt to testbench/top

Behaviour:
- Reset: every output is 0, including ex_valid, halt_pending, is_halted and the drain counter. Reset asserted mid-drain or after halt clears everything on that edge.
- Capture condition on each edge: take = id_valid & ~id_bubble & ~halt_pending & ~is_halted.
- take = 1: all ex_* outputs load their id_* counterparts; ex_valid = 1. Latency is exactly 1 cycle.
- take = 0 (bubble): ex_valid = 0, all six control outputs = 0, ex_rd/ex_rs1/ex_rs2 = 0 so forwarding sees x0. Data fields (pc, operands, imm, funct) load 0.
- No hold/stall-freeze mode: the register always advances; stalls are expressed only as bubbles.
- Halt arm: on an edge with take & id_is_ecall & id_halt_req, set halt_pending and load the drain counter with DRAIN_CYCLES-1.
- Ecall without id_halt_req passes through as a normal instruction and does not arm.
- While halt_pending: every capture is a bubble; the counter decrements each edge.
- On the edge where the counter is 0 and halt_pending is 1: clear halt_pending, set is_halted. Net effect: ecall captured at edge k gives is_halted = 1 after edge k+DRAIN_CYCLES.
- is_halted is sticky until reset. Further captures are bubbles.
- Simultaneous events: reset > halt logic > bubble > capture. id_bubble with a halting ecall means the ecall is not captured and not armed; it re-presents next cycle.

Optional Feature:
- Macro: ID_EX_BUBBLE_CNT_EN.
- Defined: adds output bubble_count (32 bits), reset to 0, increments on every edge with take = 0 & ~is_halted, and saturates at 0xFFFFFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package/header (alongside opcodes.v): control-bundle field widths, register index width 5, DRAIN_CYCLES default, and the halt register number/value (17, 10).
- One natural sub-module: halt_drain_seq. It holds halt_pending, the counter and is_halted; inputs are clk, reset, arm; outputs are halt_pending and is_halted.

Test Plan:
- Reset held 2 cycles with ADD bundle on inputs -> all outputs 0; first edge after release captures: ex_valid=1, ex_write_enable=1, ex_rd=5, ex_rs1_data=0x0000_0010.
- LW captured, then id_bubble=1 one cycle -> next cycle ex_valid=0, all controls 0, ex_rd=0; following cycle dependent ADD captured normally.
- id_valid=0 with id_mem_write=1 -> ex_mem_write=0, ex_valid=0.
- Ecall with id_halt_req=1 captured at edge k, ADDI presented afterwards -> halt_pending=1 edges k..k+2; ADDI never appears (ex_valid=0); is_halted=1 after edge k+3 and stays 1.
- Ecall with id_halt_req=0 -> ex_is_ecall=1 for one cycle, halt_pending stays 0, pipeline continues.
- Reset asserted at edge k+1 mid-drain -> halt_pending=0, is_halted=0, ex_valid=0; new instruction captured after release. With ID_EX_BUBBLE_CNT_EN: three bubbles -> bubble_count=3.

Source files
------------

// File: rtl/id_ex_pipe_reg_pkg.sv
// rtl/id_ex_pipe_reg_pkg.sv - shared widths, halt constants and types for the ID/EX register
package id_ex_pipe_reg_pkg;

    localparam int REG_IDX_W        = 5;
    localparam int FUNCT3_W         = 3;
    localparam int FUNCT7_W         = 7;
    localparam int CTRL_W           = 6;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int DRAIN_CNT_W      = 8;
    localparam int HALT_REG_NUM     = 17;
    localparam int HALT_REG_VAL     = 10;

    typedef struct packed {
        logic mem_read;
        logic mem_to_reg;
        logic mem_write;
        logic alu_src;
        logic write_enable;
        logic is_ecall;
    } ctrl_t;

    typedef enum logic [1:0] {
        HALT_IDLE  = 2'd0,
        HALT_DRAIN = 2'd1,
        HALT_DONE  = 2'd2
    } halt_state_t;

endpackage

// File: rtl/id_ex_pipe_reg_halt_drain_seq.sv
// rtl/id_ex_pipe_reg_halt_drain_seq.sv - ecall drain sequencer: arm, count down, sticky halt
module halt_drain_seq
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic arm,
    output logic halt_pending,
    output logic is_halted
);

    halt_state_t            state_d, state_q;
    logic [DRAIN_CNT_W-1:0] cnt_d, cnt_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            HALT_IDLE: begin
                if (arm) begin
                    state_d = HALT_DRAIN;
                    cnt_d   = DRAIN_CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            HALT_DRAIN: begin
                // Counter at zero means the ecall has just left WB.
                if (cnt_q == '0) begin
                    state_d = HALT_DONE;
                end else begin
                    cnt_d = cnt_q - DRAIN_CNT_W'(1);
                end
            end
            HALT_DONE: state_d = HALT_DONE;
            default:   state_d = HALT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= HALT_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign halt_pending = (state_q == HALT_DRAIN);
    assign is_halted    = (state_q == HALT_DONE);

endmodule

// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - ID/EX pipeline register with bubbles and ecall halt drain (option: ID_EX_BUBBLE_CNT_EN)
module id_ex_pipe_reg
    import id_ex_pipe_reg_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic                 id_bubble,
    input  logic                 id_mem_read,
    input  logic                 id_mem_to_reg,
    input  logic                 id_mem_write,
    input  logic                 id_alu_src,
    input  logic                 id_write_enable,
    input  logic                 id_is_ecall,
    input  logic                 id_halt_req,
    input  logic [XLEN-1:0]      id_pc,
    input  logic [XLEN-1:0]      id_rs1_data,
    input  logic [XLEN-1:0]      id_rs2_data,
    input  logic [XLEN-1:0]      id_imm,
    input  logic [FUNCT3_W-1:0]  id_funct3,
    input  logic [FUNCT7_W-1:0]  id_funct7,
    input  logic [REG_IDX_W-1:0] id_rs1,
    input  logic [REG_IDX_W-1:0] id_rs2,
    input  logic [REG_IDX_W-1:0] id_rd,
    output logic                 ex_valid,
    output logic                 ex_mem_read,
    output logic                 ex_mem_to_reg,
    output logic                 ex_mem_write,
    output logic                 ex_alu_src,
    output logic                 ex_write_enable,
    output logic                 ex_is_ecall,
    output logic [XLEN-1:0]      ex_pc,
    output logic [XLEN-1:0]      ex_rs1_data,
    output logic [XLEN-1:0]      ex_rs2_data,
    output logic [XLEN-1:0]      ex_imm,
    output logic [FUNCT3_W-1:0]  ex_funct3,
    output logic [FUNCT7_W-1:0]  ex_funct7,
    output logic [REG_IDX_W-1:0] ex_rs1,
    output logic [REG_IDX_W-1:0] ex_rs2,
    output logic [REG_IDX_W-1:0] ex_rd,
`ifdef ID_EX_BUBBLE_CNT_EN
    output logic [31:0]          bubble_count,
`endif
    output logic                 halt_pending,
    output logic                 is_halted
);

    logic                 take;
    logic                 arm;
    logic                 valid_d, valid_q;
    ctrl_t                ctrl_d, ctrl_q;
    logic [XLEN-1:0]      pc_d, pc_q;
    logic [XLEN-1:0]      rs1_data_d, rs1_data_q;
    logic [XLEN-1:0]      rs2_data_d, rs2_data_q;
    logic [XLEN-1:0]      imm_d, imm_q;
    logic [FUNCT3_W-1:0]  funct3_d, funct3_q;
    logic [FUNCT7_W-1:0]  funct7_d, funct7_q;
    logic [REG_IDX_W-1:0] rs1_d, rs1_q;
    logic [REG_IDX_W-1:0] rs2_d, rs2_q;
    logic [REG_IDX_W-1:0] rd_d, rd_q;

    // A bubble zeroes every field, so forwarding compares against x0.
    always_comb begin
        take       = id_valid & ~id_bubble & ~halt_pending & ~is_halted;
        arm        = take & id_is_ecall & id_halt_req;
        valid_d    = take;
        ctrl_d     = '0;
        pc_d       = '0;
        rs1_data_d = '0;
        rs2_data_d = '0;
        imm_d      = '0;
        funct3_d   = '0;
        funct7_d   = '0;
        rs1_d      = '0;
        rs2_d      = '0;
        rd_d       = '0;
        if (take) begin
            ctrl_d.mem_read     = id_mem_read;
            ctrl_d.mem_to_reg   = id_mem_to_reg;
            ctrl_d.mem_write    = id_mem_write;
            ctrl_d.alu_src      = id_alu_src;
            ctrl_d.write_enable = id_write_enable;
            ctrl_d.is_ecall     = id_is_ecall;
            pc_d                = id_pc;
            rs1_data_d          = id_rs1_data;
            rs2_data_d          = id_rs2_data;
            imm_d               = id_imm;
            funct3_d            = id_funct3;
            funct7_d            = id_funct7;
            rs1_d               = id_rs1;
            rs2_d               = id_rs2;
            rd_d                = id_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= 1'b0;
            ctrl_q     <= '0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            funct3_q   <= '0;
            funct7_q   <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
        end else begin
            valid_q    <= valid_d;
            ctrl_q     <= ctrl_d;
            pc_q       <= pc_d;
            rs1_data_q <= rs1_data_d;
            rs2_data_q <= rs2_data_d;
            imm_q      <= imm_d;
            funct3_q   <= funct3_d;
            funct7_q   <= funct7_d;
            rs1_q      <= rs1_d;
            rs2_q      <= rs2_d;
            rd_q       <= rd_d;
        end
    end

    halt_drain_seq #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_halt_drain_seq (
        .clk          (clk),
        .reset        (reset),
        .arm          (arm),
        .halt_pending (halt_pending),
        .is_halted    (is_halted)
    );

`ifdef ID_EX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt_d, bubble_cnt_q;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!take && !is_halted && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_count = bubble_cnt_q;
`endif

    assign ex_valid        = valid_q;
    assign ex_mem_read     = ctrl_q.mem_read;
    assign ex_mem_to_reg   = ctrl_q.mem_to_reg;
    assign ex_mem_write    = ctrl_q.mem_write;
    assign ex_alu_src      = ctrl_q.alu_src;
    assign ex_write_enable = ctrl_q.write_enable;
    assign ex_is_ecall     = ctrl_q.is_ecall;
    assign ex_pc           = pc_q;
    assign ex_rs1_data     = rs1_data_q;
    assign ex_rs2_data     = rs2_data_q;
    assign ex_imm          = imm_q;
    assign ex_funct3       = funct3_q;
    assign ex_funct7       = funct7_q;
    assign ex_rs1          = rs1_q;
    assign ex_rs2          = rs2_q;
    assign ex_rd           = rd_q;

endmodule
